// File: rtl/twisted_ring_shift_unit_pkg.sv
// Shared mode encoding and period helper for the twisted-ring shift unit.
package twisted_ring_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_ROR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_JR   = 3'b101,
    MODE_JL   = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  // Steps per full cycle; Johnson modes visit 2*W states, plain modes W.
  function automatic int unsigned period(input mode_e m, input int unsigned w);
    return (m == MODE_JR || m == MODE_JL) ? 2 * w : w;
  endfunction

endpackage

// File: rtl/twisted_ring_shift_unit_if.sv
// Control/data bundle between a driver and the twisted-ring shift unit.
interface twisted_ring_shift_unit_if #(
  parameter int WIDTH = 6
) ();
  localparam int CW = $clog2(2 * WIDTH);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [2:0]       mode;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             illegal;
  logic [CW-1:0]    step_cnt;

  modport master (
    output en, load, load_value, mode, ser_in,
    input  q, wrap, illegal, step_cnt
  );

  modport slave (
    input  en, load, load_value, mode, ser_in,
    output q, wrap, illegal, step_cnt
  );
endinterface

// File: rtl/twisted_ring_shift_unit_johnson_legal_check.sv
// Flags a register value that is not one of the 2*WIDTH Johnson-counter states.
module johnson_legal_check #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] q,
  output logic             illegal
);
  localparam logic [WIDTH-2:0] ONE = (WIDTH-1)'(1);

  logic [WIDTH-2:0] diff;

  // One bit per adjacent-bit transition; legal means at most one bit set.
  assign diff    = q[WIDTH-1:1] ^ q[WIDTH-2:0];
  assign illegal = |(diff & (diff - ONE));
endmodule

// File: rtl/twisted_ring_shift_unit.sv
// Shift/rotate/Johnson register with period tracking and wrap pulse.
// Optional TWISTED_RING_SELF_CORRECT_EN: Johnson steps from an illegal state reload zero.
module twisted_ring_shift_unit
  import twisted_ring_pkg::*;
#(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  twisted_ring_shift_unit_if.slave bus
);
  localparam int CW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] q_r, q_nxt;
  logic [CW-1:0]    cnt_r;
  logic             wrap_r;
  mode_e            mode_r, mode_in;
  logic             illegal, mode_chg, step, at_end, fix;

  assign mode_in  = mode_e'(bus.mode);
  assign mode_chg = (mode_in != mode_r);
  assign step     = bus.en && !mode_chg && mode_in != MODE_HOLD && mode_in != MODE_RSVD;
  assign at_end   = (32'(cnt_r) == period(mode_in, WIDTH) - 1);

`ifdef TWISTED_RING_SELF_CORRECT_EN
  assign fix = step && illegal && (mode_in == MODE_JR || mode_in == MODE_JL);
`else
  assign fix = 1'b0;
`endif

  johnson_legal_check #(.WIDTH(WIDTH)) u_legal (
    .q       (q_r),
    .illegal (illegal)
  );

  always_comb begin
    q_nxt = q_r;
    case (mode_in)
      MODE_SHR: q_nxt = {bus.ser_in, q_r[WIDTH-1:1]};
      MODE_SHL: q_nxt = {q_r[WIDTH-2:0], bus.ser_in};
      MODE_ROR: q_nxt = {q_r[0], q_r[WIDTH-1:1]};
      MODE_ROL: q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
      MODE_JR:  q_nxt = {~q_r[0], q_r[WIDTH-1:1]};
      MODE_JL:  q_nxt = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
      default:  q_nxt = q_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= RESET_VALUE;
      cnt_r  <= '0;
      wrap_r <= 1'b0;
      mode_r <= MODE_HOLD;
    end else begin
      // Mode tracking follows en so a change made while disabled is seen on re-enable.
      if (bus.en) mode_r <= mode_in;
      if (bus.load) begin
        q_r    <= bus.load_value;
        cnt_r  <= '0;
        wrap_r <= 1'b0;
      end else if (fix) begin
        q_r    <= '0;
        cnt_r  <= '0;
        wrap_r <= 1'b0;
      end else if (step) begin
        q_r <= q_nxt;
        if (at_end) begin
          cnt_r  <= '0;
          wrap_r <= 1'b1;
        end else begin
          cnt_r  <= cnt_r + CW'(1);
          wrap_r <= 1'b0;
        end
      end else begin
        wrap_r <= 1'b0;
        if (bus.en && mode_chg) cnt_r <= '0;
      end
    end
  end

  assign bus.q        = q_r;
  assign bus.step_cnt = cnt_r;
  assign bus.wrap     = wrap_r;
  assign bus.illegal  = illegal;
endmodule
